// File: rtl/wave_osc_pkg.sv
// Shared definitions for the wave_osc oscillator: mode encodings and reset constants.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package wave_osc_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } mode_e;

  // Active mode after reset.
  localparam mode_e MODE_RESET = MODE_SQUARE;

  // Active duty after reset is half scale: 2^(res_bits-1).
  function automatic int unsigned duty_reset_value(input int unsigned res_bits);
    return 32'd1 << (res_bits - 1);
  endfunction

endpackage

// File: rtl/wave_osc_phase_accumulator.sv
// Phase accumulator: ACC_WIDTH register advancing by incr_i every clock, with adder carry-out.
// Latency: phase register updates one clock after incr_i is presented; carry_o is combinational.
// Backpressure: none; free-running every cycle.
module phase_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [ACC_WIDTH-1:0] incr_i,
  output logic [OUT_WIDTH-1:0] phase_msb_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH-1:0] phase_q;
  logic [ACC_WIDTH-1:0] phase_d;

  // Wrapping add; the bit that falls off the top is the wrap indication.
  always_comb begin
    {carry_o, phase_d} = {1'b0, phase_q} + {1'b0, incr_i};
  end

  // Phase register, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_msb_o = phase_q[ACC_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: rtl/wave_osc.sv
// Phase-accumulator oscillator: square / pulse / saw / triangle with wrap-aligned double-buffered controls.
// Latency: wave_out lags phase by 1 clock; load -> busy 1 clock; active change -> first affected sample 2 clocks.
// Backpressure: none; one sample per clock. Build macro WAVE_OSC_TRIANGLE_EN enables the triangle shaper (else mode 3 = saw).
module wave_osc
  import wave_osc_pkg::*;
#(
  parameter int ACC_WIDTH       = 16,
  parameter int FREQ_WIDTH      = 8,
  parameter int RESOLUTION_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [FREQ_WIDTH-1:0]      frequency_control,
  input  logic [1:0]                 mode,
  input  logic [RESOLUTION_BITS-1:0] duty,
  output logic [RESOLUTION_BITS-1:0] wave_out,
  output logic                       wrap,
  output logic                       busy
);

  localparam int RES = RESOLUTION_BITS;
  localparam logic [RES-1:0] DUTY_RST = RES'(duty_reset_value(RES));

  // Active (in-use) control registers.
  logic [FREQ_WIDTH-1:0] freq_a_q, freq_a_d;
  mode_e                 mode_a_q, mode_a_d;
  logic [RES-1:0]        duty_a_q, duty_a_d;

  // Shadow registers written by load, copied to active at a safe point.
  logic [FREQ_WIDTH-1:0] freq_s_q, freq_s_d;
  mode_e                 mode_s_q, mode_s_d;
  logic [RES-1:0]        duty_s_q, duty_s_d;
  logic                  pending_q, pending_d;

  // Output registers.
  logic [RES-1:0]        wave_q, wave_d;
  logic                  wrap_q, wrap_d;

  logic [ACC_WIDTH-1:0]  incr;
  logic [RES-1:0]        p;
  logic                  carry;
  logic                  apply;

  assign incr = ACC_WIDTH'(freq_a_q);

  phase_accumulator #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (RES)
  ) u_phase_accumulator (
    .clk_i       (clk),
    .reset_i     (reset),
    .incr_i      (incr),
    .phase_msb_o (p),
    .carry_o     (carry)
  );

  // Shadow/active update: apply at a wrap or immediately when stopped; a load lands in the shadow after any apply.
  always_comb begin
    apply     = pending_q && (carry || (freq_a_q == '0));
    freq_a_d  = freq_a_q;
    mode_a_d  = mode_a_q;
    duty_a_d  = duty_a_q;
    freq_s_d  = freq_s_q;
    mode_s_d  = mode_s_q;
    duty_s_d  = duty_s_q;
    pending_d = pending_q;
    if (apply) begin
      freq_a_d  = freq_s_q;
      mode_a_d  = mode_s_q;
      duty_a_d  = duty_s_q;
      pending_d = 1'b0;
    end
    if (load) begin
      freq_s_d  = frequency_control;
      mode_s_d  = mode_e'(mode);
      duty_s_d  = duty;
      pending_d = 1'b1;
    end
  end

  // Waveform shaping from the current phase top bits; registered below.
  always_comb begin
    wave_d = '0;
    wrap_d = carry;
    case (mode_a_q)
      MODE_SQUARE: wave_d = p[RES-1] ? '0 : '1;
      MODE_PULSE:  wave_d = (p < duty_a_q) ? '1 : '0;
      MODE_SAW:    wave_d = p;
`ifdef WAVE_OSC_TRIANGLE_EN
      // Fold the upper half back down: rises 0..MAX-1 in steps of 2, then falls to 0.
      MODE_TRI:    wave_d = {p[RES-2:0] ^ {(RES-1){p[RES-1]}}, 1'b0};
`else
      MODE_TRI:    wave_d = p;
`endif
      default:     wave_d = p;
    endcase
  end

  // Control and output state; reset discards any pending update.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_a_q  <= '0;
      mode_a_q  <= MODE_RESET;
      duty_a_q  <= DUTY_RST;
      freq_s_q  <= '0;
      mode_s_q  <= MODE_SQUARE;
      duty_s_q  <= '0;
      pending_q <= 1'b0;
      wave_q    <= '0;
      wrap_q    <= 1'b0;
    end else begin
      freq_a_q  <= freq_a_d;
      mode_a_q  <= mode_a_d;
      duty_a_q  <= duty_a_d;
      freq_s_q  <= freq_s_d;
      mode_s_q  <= mode_s_d;
      duty_s_q  <= duty_s_d;
      pending_q <= pending_d;
      wave_q    <= wave_d;
      wrap_q    <= wrap_d;
    end
  end

  assign wave_out = wave_q;
  assign wrap     = wrap_q;
  assign busy     = pending_q;

endmodule

// File: tb/tb_wave_osc.sv
// Self-checking bench for wave_osc at ACC_WIDTH=8, FREQ_WIDTH=8, RESOLUTION_BITS=8.
// A cycle-level arithmetic reference model predicts wave_out/wrap/busy; scenario tasks add direct checks.
// Stimulus is driven on the falling edge and outputs are compared on the falling edge.
module tb_wave_osc;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] frequency_control;
  logic [1:0] mode;
  logic [7:0] duty;
  logic [7:0] wave_out;
  logic       wrap;
  logic       busy;

  always #5 clk = ~clk;

  wave_osc #(
    .ACC_WIDTH       (8),
    .FREQ_WIDTH      (8),
    .RESOLUTION_BITS (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .load              (load),
    .frequency_control (frequency_control),
    .mode              (mode),
    .duty              (duty),
    .wave_out          (wave_out),
    .wrap              (wrap),
    .busy              (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state (values as seen after each rising edge).
  int m_phase = 0, m_freq = 0, m_mode = 0, m_duty = 128;
  int s_freq = 0, s_mode = 0, s_duty = 0;
  int m_wave = 0;
  bit m_wrap = 0, m_pend = 0;

  // Sample value for a phase (accumulator and output both 8 bits, so p is the phase).
  function automatic int shape(input int ph, input int md, input int dt);
    case (md)
      0: return (ph < 128) ? 255 : 0;
      1: return (ph < dt) ? 255 : 0;
      2: return ph;
      default: begin
`ifdef WAVE_OSC_TRIANGLE_EN
        return (ph < 128) ? 2 * ph : 2 * (255 - ph);
`else
        return ph;
`endif
      end
    endcase
  endfunction

  task automatic model_step();
    int sum;
    bit carry;
    bit apply;
    cyc++;
    if (reset) begin
      m_phase = 0; m_wave = 0; m_wrap = 0; m_pend = 0;
      m_freq = 0; m_mode = 0; m_duty = 128;
      s_freq = 0; s_mode = 0; s_duty = 0;
    end else begin
      sum    = m_phase + m_freq;
      carry  = (sum >= 256);
      m_wave = shape(m_phase, m_mode, m_duty);
      m_wrap = carry;
      apply  = m_pend && (carry || m_freq == 0);
      m_phase = sum % 256;
      if (apply) begin
        m_freq = s_freq; m_mode = s_mode; m_duty = s_duty; m_pend = 0;
      end
      if (load) begin
        s_freq = int'(frequency_control); s_mode = int'(mode); s_duty = int'(duty); m_pend = 1;
      end
    end
  endtask

  function automatic logic [9:0] expv();
    return {m_wave[7:0], m_wrap, m_pend};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_load(input int f, input int md, input int dt);
    frequency_control = 8'(f);
    mode              = 2'(md);
    duty              = 8'(dt);
    load              = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_load(200, 2, 7);
    tick();
    tick();
    reset = 1'b0;
    load  = 1'b0;
    n_checks++;
    if ({wave_out, wrap, busy} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=%h", {wave_out, wrap, busy}, 10'd0);
    end
    n_checks++;
    if ({wave_out, wrap, busy} !== expv()) begin
      n_fail++;
      $display("FAIL reset_model got=%h want=%h", {wave_out, wrap, busy}, expv());
    end
  endtask

  task automatic test_square();
    int wraps = 0;
    int highs = 0;
    drive_load(16, 0, 0);
    tick();
    load = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL square_busy_high got=%b want=1", busy); end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL square_busy_low got=%b want=0", busy); end
    for (int i = 0; i < 64; i++) begin
      tick();
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL square cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
      if (wrap === 1'b1) wraps++;
      if (i >= 32 && wave_out === 8'd255) highs++;
    end
    n_checks++;
    if (wraps != 4) begin n_fail++; $display("FAIL square_wrap_count got=%0d want=4", wraps); end
    n_checks++;
    if (highs != 16) begin n_fail++; $display("FAIL square_duty got=%0d want=16", highs); end
  endtask

  task automatic test_freq_change();
    int busy_cnt = 0;
    int prev, run, seg, bad;
    for (int i = 0; i < 32 && m_phase != 64; i++) tick();
    n_checks++;
    if (m_phase != 64) begin n_fail++; $display("FAIL fchg_align got=%0d want=64", m_phase); end
    drive_load(2, 0, 0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      busy_cnt++;
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL fchg_pending cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
      tick();
    end
    n_checks++;
    if (busy_cnt != 11) begin n_fail++; $display("FAIL fchg_busy_len got=%0d want=11", busy_cnt); end
    prev = int'(wave_out); run = 1; seg = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL fchg cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
      if (int'(wave_out) == prev) run++;
      else begin
        if (seg > 0 && run != 8 && run != 64) bad++;
        seg++; run = 1; prev = int'(wave_out);
      end
    end
    n_checks++;
    if (bad != 0 || seg < 3) begin
      n_fail++;
      $display("FAIL fchg_segments got bad=%0d segs=%0d want bad=0 segs>=3", bad, seg);
    end
  endtask

  task automatic test_pulse();
    int highs = 0;
    drive_load(16, 1, 64);
    tick();
    load = 1'b0;
    for (int i = 0; i < 300 && busy === 1'b1; i++) tick();
    for (int i = 0; i < 48; i++) begin
      tick();
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL pulse cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
      if (i >= 16 && wave_out === 8'd255) highs++;
    end
    n_checks++;
    if (highs != 8) begin n_fail++; $display("FAIL pulse_duty64 got=%0d want=8", highs); end
    drive_load(16, 1, 0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL pulse0 cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
      if (wave_out !== 8'd0) highs++;
    end
    n_checks++;
    if (highs != 0) begin n_fail++; $display("FAIL pulse_duty0 got=%0d want=0", highs); end
  endtask

  task automatic test_shapes();
    int want;
    for (int md = 2; md <= 3; md++) begin
      drive_load(16, md, 0);
      tick();
      load = 1'b0;
      for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
      for (int i = 0; i < 20; i++) tick();
      for (int i = 0; i < 32 && wave_out !== 8'd0; i++) tick();
      for (int k = 0; k < 16; k++) begin
        want = 16 * k;
`ifdef WAVE_OSC_TRIANGLE_EN
        if (md == 3) want = (k < 8) ? 32 * k : 2 * (255 - 16 * k);
`endif
        n_checks++;
        if (wave_out !== 8'(want)) begin
          n_fail++;
          $display("FAIL shape_mode%0d step=%0d got=%0d want=%0d", md, k, wave_out, want);
        end
        n_checks++;
        if ({wave_out, wrap, busy} !== expv()) begin
          n_fail++;
          $display("FAIL shape_model cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
        end
        tick();
      end
    end
  endtask

  task automatic test_load_on_carry();
    int busy_cnt = 0;
    drive_load(32, 2, 0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 40 && (m_phase + m_freq) < 256; i++) tick();
    n_checks++;
    if ((m_phase + m_freq) < 256 || m_pend != 1'b1) begin
      n_fail++;
      $display("FAIL carry_align got phase=%0d pend=%0d want carry with pending", m_phase, m_pend);
    end
    drive_load(8, 0, 0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 64 && busy === 1'b1; i++) begin
      busy_cnt++;
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL carry_load cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
      tick();
    end
    n_checks++;
    if (busy_cnt != 8) begin n_fail++; $display("FAIL carry_busy_len got=%0d want=8", busy_cnt); end
  endtask

  task automatic test_double_load();
    int wraps = 0;
    drive_load(64, 0, 0);
    tick();
    drive_load(4, 2, 0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 80 && busy === 1'b1; i++) tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL dbl_timeout got busy=%b want=0", busy); end
    for (int i = 0; i < 128; i++) begin
      tick();
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL dbl cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
      if (wrap === 1'b1) wraps++;
    end
    n_checks++;
    if (wraps != 2) begin n_fail++; $display("FAIL dbl_wraps got=%0d want=2", wraps); end
  endtask

  task automatic test_reset_pending();
    drive_load(1, 1, 200);
    tick();
    load = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstp_busy got=%b want=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({wave_out, wrap, busy} !== 10'd0) begin
      n_fail++;
      $display("FAIL rstp_outputs got=%h want=%h", {wave_out, wrap, busy}, 10'd0);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (wave_out !== 8'd255 || busy !== 1'b0 || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL rstp_frozen got=%h/%b/%b want=ff/0/0", wave_out, wrap, busy);
      end
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL rstp_model cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset             = ($urandom_range(0, 399) == 0);
      load              = ($urandom_range(0, 9) == 0);
      frequency_control = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      mode              = 2'($urandom);
      duty              = 8'($urandom);
      tick();
      n_checks++;
      if ({wave_out, wrap, busy} !== expv()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, {wave_out, wrap, busy}, expv());
      end
    end
    reset = 1'b0;
    load  = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    load              = 1'b0;
    frequency_control = 8'd0;
    mode              = 2'd0;
    duty              = 8'd0;
    test_reset();
    test_square();
    test_freq_change();
    test_pulse();
    test_shapes();
    test_load_on_carry();
    test_double_load();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
